// File: rtl/id_ex_stage.sv
// ID->EX pipeline register: operand capture, PC/immediate select, MEM/WB forwarding, load-use bubbles.
// Optional feature macro: FORWARDING_EN (undefined = no output forwarding, interlock on any RAW hazard).
module id_ex_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               id_valid,
  output logic               id_ready,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [RADDR_W-1:0] id_rs1_addr,
  input  logic [RADDR_W-1:0] id_rs2_addr,
  input  logic               id_rs1_used,
  input  logic               id_rs2_used,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic               id_use_pc,
  input  logic               id_use_imm,
  input  logic [3:0]         id_alu_op,
  input  logic [RADDR_W-1:0] id_rd_addr,
  input  logic               id_rd_we,
  input  logic               id_is_load,
  input  logic [RADDR_W-1:0] mem_rd_addr,
  input  logic               mem_rd_we,
  input  logic [XLEN-1:0]    mem_rd_data,
  input  logic [RADDR_W-1:0] wb_rd_addr,
  input  logic               wb_rd_we,
  input  logic [XLEN-1:0]    wb_rd_data,
  output logic               ex_valid,
  input  logic               ex_ready,
  output logic [XLEN-1:0]    ex_in_0,
  output logic [XLEN-1:0]    ex_in_1,
  output logic [3:0]         ex_operation,
  output logic [XLEN-1:0]    ex_store_data,
  output logic [RADDR_W-1:0] ex_rd_addr,
  output logic               ex_rd_we,
  output logic               ex_is_load
);

  logic               r_valid;
  logic [XLEN-1:0]    r_pc, r_rs1_data, r_rs2_data, r_imm;
  logic [RADDR_W-1:0] r_rs1_addr, r_rs2_addr, r_rd_addr;
  logic               r_use_pc, r_use_imm, r_rd_we, r_is_load;
  logic [3:0]         r_alu_op;

  logic               w_dep_ex, w_lu_stall, w_stall, w_accept;
  logic [XLEN-1:0]    w_cap_rs1, w_cap_rs2, w_fwd_rs1, w_fwd_rs2;

  // Does the instruction on offer read the register held in EX?
  assign w_dep_ex = (r_rd_addr != '0) && id_valid &&
                    ((id_rs1_used && id_rs1_addr == r_rd_addr) ||
                     (id_rs2_used && id_rs2_addr == r_rd_addr));

  assign w_lu_stall = r_valid && r_is_load && r_rd_we && w_dep_ex;

`ifdef FORWARDING_EN
  assign w_stall = w_lu_stall;

  // NOTE: every signal gets a default before the priority chain so no latch is inferred.
  always_comb begin
    w_fwd_rs1 = r_rs1_data;
    w_fwd_rs2 = r_rs2_data;
    if (r_rs1_addr != '0 && mem_rd_we && mem_rd_addr == r_rs1_addr)
      w_fwd_rs1 = mem_rd_data;
    else if (r_rs1_addr != '0 && wb_rd_we && wb_rd_addr == r_rs1_addr)
      w_fwd_rs1 = wb_rd_data;
    if (r_rs2_addr != '0 && mem_rd_we && mem_rd_addr == r_rs2_addr)
      w_fwd_rs2 = mem_rd_data;
    else if (r_rs2_addr != '0 && wb_rd_we && wb_rd_addr == r_rs2_addr)
      w_fwd_rs2 = wb_rd_data;
  end
`else
  logic w_dep_mem;
  logic w_unused;

  assign w_dep_mem = (mem_rd_addr != '0) && id_valid &&
                     ((id_rs1_used && id_rs1_addr == mem_rd_addr) ||
                      (id_rs2_used && id_rs2_addr == mem_rd_addr));

  // Without forwarding, wait until every producer has reached the regfile write port.
  assign w_stall   = w_lu_stall || (r_valid && r_rd_we && w_dep_ex) || (mem_rd_we && w_dep_mem);
  assign w_fwd_rs1 = r_rs1_data;
  assign w_fwd_rs2 = r_rs2_data;
  assign w_unused  = ^{mem_rd_data, r_rs1_addr, r_rs2_addr};
`endif

  assign id_ready = !w_stall && (!r_valid || ex_ready);
  assign w_accept = id_valid && id_ready;

  // WB writes this cycle are not yet visible in the regfile read data.
  assign w_cap_rs1 = (wb_rd_we && wb_rd_addr != '0 && wb_rd_addr == id_rs1_addr) ? wb_rd_data : id_rs1_data;
  assign w_cap_rs2 = (wb_rd_we && wb_rd_addr != '0 && wb_rd_addr == id_rs2_addr) ? wb_rd_data : id_rs2_data;

  // NOTE: state uses non-blocking assignments; all fields are reset so outputs are defined out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rd_addr  <= '0;
      r_use_pc   <= 1'b0;
      r_use_imm  <= 1'b0;
      r_rd_we    <= 1'b0;
      r_is_load  <= 1'b0;
      r_alu_op   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid    <= 1'b1;
      r_pc       <= id_pc;
      r_rs1_data <= w_cap_rs1;
      r_rs2_data <= w_cap_rs2;
      r_imm      <= id_imm;
      r_rs1_addr <= id_rs1_addr;
      r_rs2_addr <= id_rs2_addr;
      r_rd_addr  <= id_rd_addr;
      r_use_pc   <= id_use_pc;
      r_use_imm  <= id_use_imm;
      r_rd_we    <= id_rd_we;
      r_is_load  <= id_is_load;
      r_alu_op   <= id_alu_op;
    end else if (ex_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign ex_valid      = r_valid;
  assign ex_in_0       = r_use_pc  ? r_pc  : w_fwd_rs1;
  assign ex_in_1       = r_use_imm ? r_imm : w_fwd_rs2;
  assign ex_store_data = w_fwd_rs2;
  assign ex_operation  = r_alu_op;
  assign ex_rd_addr    = r_rd_addr;
  assign ex_rd_we      = r_rd_we;
  assign ex_is_load    = r_is_load;

endmodule
